// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, trap/mret handling, halt and fetch handshake
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fetch_ready         imem accepts pc_out this cycle
//   stall               core stall, holds pc
//   redirect_valid/_target  branch/jump request and destination
//   trap_valid          exception/interrupt entry
//   mret_valid          return from trap
//   halt_req            halt after current instruction
//   pc_out, pc_plus4    fetch address and its sequential successor
//   fetch_valid         pc_out is a valid fetch request
//   epc_out             saved exception pc
//   misaligned          one-cycle pulse on a misaligned redirect turned into a trap
//   halted              unit is in HALT
module pc_unit #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0010,
  parameter int unsigned INC_BYTES = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            mret_valid,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc_out,
  output logic            misaligned,
  output logic            halted
);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_rv_chk
    $error("RESET_VECTOR is not aligned");
  end
  if ((TRAP_VECTOR & ALIGN_MASK) != '0) begin : g_tv_chk
    $error("TRAP_VECTOR is not aligned");
  end
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic mis_q, mis_d;
  logic advance, aligned;
  assign advance = !stall && fetch_ready;
  assign aligned = (redirect_target & ALIGN_MASK) == '0;
  assign pc_out = pc_q;
  assign pc_plus4 = pc_q + XLEN'(INC_BYTES);
  assign epc_out = epc_q;
  assign misaligned = mis_q;
  assign fetch_valid = state_q == RUN;
  assign halted = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    epc_d = epc_q;
    mis_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid) begin
          epc_d = pc_q;
          pc_d = TRAP_VECTOR;
        end else if (advance) begin
          if (mret_valid) pc_d = epc_q;
          else if (redirect_valid && aligned) pc_d = redirect_target;
          else if (redirect_valid) begin
            epc_d = pc_q;
            pc_d = TRAP_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
            state_d = halt_req ? HALT : RUN;
          end
        end
      end
      HALT: begin
        // only a trap or a redirect wakes the unit; everything else is ignored
        if (trap_valid || redirect_valid) state_d = RUN;
        if (trap_valid || (redirect_valid && !aligned)) begin
          epc_d = pc_q;
          pc_d = TRAP_VECTOR;
          mis_d = !trap_valid;
        end else if (redirect_valid) pc_d = redirect_target;
      end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus randomized check of pc_unit against a behavioural model
module tb_pc_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic fetch_ready = 1'b0, stall = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
  logic mret_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic fetch_valid, misaligned, halted;
  int n_cmp = 0, n_err = 0;
  int m_st;
  logic [31:0] m_pc, m_epc;
  logic m_mis;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  localparam logic [31:0] TV = 32'h10;
  pc_unit dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .mret_valid(mret_valid), .halt_req(halt_req),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .epc_out(epc_out), .misaligned(misaligned), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = M_BOOT;
    m_pc = 32'h0;
    m_epc = 32'h0;
    m_mis = 1'b0;
  endtask
  task automatic model_trap(input logic mis);
    m_epc = m_pc;
    m_pc = TV;
    m_mis = mis;
    m_st = M_RUN;
  endtask
  task automatic model_edge();
    bit go = !stall && fetch_ready;
    bit al = redirect_target % 4 == 0;
    m_mis = 1'b0;
    if (m_st == M_BOOT) m_st = M_RUN;
    else if (trap_valid) model_trap(1'b0);
    else if (m_st == M_HALT) begin
      if (redirect_valid && al) begin m_pc = redirect_target; m_st = M_RUN; end
      else if (redirect_valid) model_trap(1'b1);
    end else if (go) begin
      if (mret_valid) m_pc = m_epc;
      else if (redirect_valid && al) m_pc = redirect_target;
      else if (redirect_valid) model_trap(1'b1);
      else begin
        m_pc = m_pc + 32'd4;
        if (halt_req) m_st = M_HALT;
      end
    end
  endtask
  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_st == M_RUN));
    chk("halted", 32'(halted), 32'(m_st == M_HALT));
    chk("epc_out", epc_out, m_epc);
    chk("misaligned", 32'(misaligned), 32'(m_mis));
  endtask
  task automatic step(input logic st, input logic rdy, input logic rv, input logic [31:0] tgt,
                      input logic tr, input logic mr, input logic hr);
    stall = st; fetch_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    trap_valid = tr; mret_valid = mr; halt_req = hr;
    @(posedge clk);
    if (!reset) model_edge();
    #1 check_all();
  endtask
  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic mid_reset();
    #3 reset = 1'b1;
    model_reset();
    #1 check_all();
    step(0, 1, 1, 32'h40, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    #1 check_all();
  endtask
  initial begin
    model_reset();
    #2 check_all();
    @(negedge clk) reset = 1'b0;
    fetch_ready = 1'b1;
    #1 check_all();
    chk("boot_fv", 32'(fetch_valid), 0);
    idle();
    chk("first_pc", pc_out, 32'h0);
    idle(); idle();
    chk("seq_pc", pc_out, 32'h8);
    step(1, 1, 1, 32'h40, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0, 0, 0);
    step(0, 0, 1, 32'h40, 0, 0, 0);
    chk("hold_pc", pc_out, 32'h8);
    step(0, 1, 1, 32'h40, 0, 0, 0);
    chk("redir_pc", pc_out, 32'h40);
    idle();
    step(0, 1, 1, 32'h102, 0, 0, 0);
    chk("mis_pc", pc_out, 32'h10);
    chk("mis_epc", epc_out, 32'h44);
    chk("mis_pulse", 32'(misaligned), 1);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("mret_pc", pc_out, 32'h44);
    chk("mis_end", 32'(misaligned), 0);
    step(0, 1, 1, 32'h20, 0, 0, 0);
    step(1, 1, 1, 32'h60, 1, 1, 0);
    chk("trap_pc", pc_out, 32'h10);
    chk("trap_epc", epc_out, 32'h20);
    step(0, 1, 1, 32'h30, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("halt_pc", pc_out, 32'h34);
    chk("halt_flag", 32'(halted), 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, i[0], 1);
    chk("halt_hold", pc_out, 32'h34);
    step(0, 1, 1, 32'h80, 0, 0, 0);
    chk("wake_pc", pc_out, 32'h80);
    step(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0);
    idle(); idle();
    chk("wrap_pc", pc_out, 32'h0);
    step(0, 1, 1, 32'h200, 0, 0, 0);
    mid_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
      step($urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, t,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the rv32i core. It replaces the bare PC register with a unit that owns next-PC selection.
- Next-PC selection covers sequential increment, stall/backpressure hold, branch/jump redirect, trap entry with saved exception PC, return-from-trap, and halt/resume.
- Sits between the control/branch logic and instruction-memory fetch. Drives the fetch address with a valid/ready handshake.

Parameters:
- XLEN, 32, width of PC, targets and EPC.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset. Must have ALIGN_BITS low bits zero (elaboration check).
- TRAP_VECTOR, 32'h0000_0010, PC loaded on trap entry. Same alignment rule as RESET_VECTOR.
- INC_BYTES, 4, sequential increment.
- ALIGN_BITS, 2, number of low target bits that must be zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- fetch_ready  in  1  imem accepts the current fetch address
- stall  in  1  core stall; hold PC
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  XLEN  branch/jump destination
- trap_valid  in  1  exception/interrupt entry request
- mret_valid  in  1  return from trap
- halt_req  in  1  request halt after current instruction
- pc_out  out  XLEN  current fetch address
- pc_plus4  out  XLEN  pc_out+INC_BYTES, combinational
- fetch_valid  out  1  pc_out is a valid fetch request
- epc_out  out  XLEN  saved exception PC
- misaligned  out  1  one-cycle pulse: misaligned redirect converted to trap
- halted  out  1  unit in HALT state

Behaviour:
- States: BOOT, RUN, HALT.
- Reset is asynchronous and may be asserted at any time, including mid-operation. On reset, all updates are abandoned and the unit returns to these values:
  - state=BOOT
  - pc_out=RESET_VECTOR
  - epc_out=0
  - fetch_valid=0
  - misaligned=0
  - halted=0
- BOOT:
  - Lasts exactly one clk edge after reset deasserts.
  - fetch_valid=0; all inputs are ignored.
  - Next state is RUN with pc_out unchanged, so the first fetch is at RESET_VECTOR.
- RUN: fetch_valid=1. Define advance = !stall && fetch_ready. Priority per edge, highest first:
  1. trap_valid (regardless of advance): epc_out<=pc_out, pc_out<=TRAP_VECTOR.
  2. !advance: hold pc_out; all other requests are ignored (the requester must keep them asserted).
  3. mret_valid: pc_out<=epc_out.
  4. redirect_valid with target[ALIGN_BITS-1:0]==0: pc_out<=redirect_target.
  5. redirect_valid with a misaligned target: epc_out<=pc_out, pc_out<=TRAP_VECTOR, misaligned=1 for exactly the next cycle.
  6. halt_req: pc_out<=pc_plus4, state<=HALT.
  7. Otherwise: pc_out<=pc_plus4.
- HALT:
  - fetch_valid=0, halted=1; pc_out held; stall, fetch_ready, mret_valid and halt_req are ignored.
  - Leaves only on one of the following, each of which returns state to RUN:
    - trap_valid: trap entry as in RUN.
    - aligned redirect_valid: pc_out<=target.
    - misaligned redirect_valid: handled as a trap with a misaligned pulse.
- Arithmetic:
  - All PC arithmetic is modulo 2^XLEN; XLEN'hFFFF_FFFC + 4 wraps to 0 with no flag.
  - pc_plus4 is valid in every state.
- Simultaneous requests follow the priority list above; lower-priority requests in the same cycle are dropped.
- epc_out changes only on trap entry, including misaligned-redirect traps.
- misaligned is a registered pulse; back-to-back misaligned redirects give back-to-back pulses.

Test Plan:
- Reset then release, fetch_ready=1, no requests -> BOOT cycle with fetch_valid=0 and pc=0. Then pc_out=0,4,8,C on consecutive edges with fetch_valid=1.
- At pc=8, stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle with redirect_valid=1 to 0x40 held throughout -> pc holds 8 for 3 cycles. After that, pc=0x40 then 0x44.
- At pc=0x44: redirect to 0x102 -> pc=0x10, epc_out=0x44, misaligned high exactly 1 cycle. Then mret_valid -> pc=0x44.
- trap_valid together with stall=1, redirect_valid and mret_valid at pc=0x20 -> pc=0x10, epc=0x20; the other requests have no effect.
- halt_req at pc=0x30 -> pc=0x34, halted=1, fetch_valid=0, pc stays 0x34 for 5 cycles. Then redirect to 0x80 -> RUN, pc=0x80.
- Redirect to 0xFFFF_FFF8 -> pc=FFFF_FFF8, FFFF_FFFC, then 0. Then assert reset mid-cycle with redirect pending -> pc_out=0, fetch_valid=0, epc=0 immediately, without waiting for a clk edge.
